// File: rtl/arb_pkg.sv
// Shared constants for the two-port arbiter and its requester front ends.
// Provides default widths, a pointer-width helper and arbiter port indices.
package arb_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int DEPTH_DEF  = 4;

    // Arbiter port indices, shared with the arbiter itself.
    localparam int REQ0 = 0;
    localparam int REQ1 = 1;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/arb_req_port_if.sv
// Producer and arbiter side signals of one requester front end.
// master: producer/arbiter side; slave: the arb_req_port block.
interface arb_req_port_if
    import arb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    localparam int CNT_W = ptr_w(DEPTH) + 1
);

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              req;
    logic              gnt;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic [CNT_W-1:0]  count;

    modport master (
        output in_valid,
        output in_data,
        output gnt,
        input  in_ready,
        input  req,
        input  out_valid,
        input  out_data,
        input  count
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  gnt,
        output in_ready,
        output req,
        output out_valid,
        output out_data,
        output count
    );

endinterface

// File: rtl/arb_req_port_sync_fifo.sv
// Synchronous FIFO: storage, wrap-around pointers, occupancy count.
// Ports: push_i/wdata_i, pop_i/rdata_o (head), count_o, full_o, empty_o.
module sync_fifo
    import arb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    localparam int PTR_W = ptr_w(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic [CNT_W-1:0]  count_o,
    output logic              full_o,
    output logic              empty_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              push_en;
    logic              pop_en;

    // Full/empty come from the count so the pointers can wrap freely.
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign push_en = push_i && !full_o;
    assign pop_en  = pop_i && !empty_o;

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CNT_W'(push_en) - CNT_W'(pop_en);
        if (push_en) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_en) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Whole array is cleared so the head reads zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_en) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/arb_req_port.sv
// Requester front end: buffers producer words, requests the arbiter, pops on grant.
// Ports: clk, reset (async active-low), bus (slave), gnt_err if ARB_REQ_PORT_ERR_EN.
module arb_req_port
    import arb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    localparam int CNT_W = ptr_w(DEPTH) + 1
) (
    input  logic           clk,
    input  logic           reset,
    arb_req_port_if.slave  bus
`ifdef ARB_REQ_PORT_ERR_EN
    ,
    output logic           gnt_err
`endif
);

    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic [CNT_W-1:0]  count;
    logic [DATA_W-1:0] head;

    // req depends only on registered state: no gnt-to-req path.
    assign bus.req       = !empty;
    assign bus.in_ready  = !full;
    assign push          = bus.in_valid && !full;
    assign pop           = bus.gnt && !empty;
    assign bus.out_valid = pop;
    assign bus.out_data  = head;
    assign bus.count     = count;

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .push_i  (push),
        .wdata_i (bus.in_data),
        .pop_i   (pop),
        .rdata_o (head),
        .count_o (count),
        .full_o  (full),
        .empty_o (empty)
    );

`ifdef ARB_REQ_PORT_ERR_EN
    logic err_q, err_d;

    // Sticky flag for a grant arriving with nothing requested.
    assign err_d   = err_q || (bus.gnt && empty);
    assign gnt_err = err_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
`endif

endmodule

// File: tb/tb_arb_req_port.sv
// Scoreboard bench for arb_req_port: queue model, directed and random traffic.
// Checks gnt_err as well when ARB_REQ_PORT_ERR_EN is defined.
module tb_arb_req_port;

    localparam int DW = 8;
    localparam int DP = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;

    arb_req_port_if #(.DATA_W(DW), .DEPTH(DP)) bus ();

`ifdef ARB_REQ_PORT_ERR_EN
    logic gnt_err;
    arb_req_port #(.DATA_W(DW), .DEPTH(DP)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .gnt_err (gnt_err)
    );
`else
    arb_req_port #(.DATA_W(DW), .DEPTH(DP)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );
`endif

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [DW-1:0] exp_q [$];
    int mcount = 0;
    bit err_m = 1'b0;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    // One cycle of stimulus; model updated at the active edge.
    task automatic step(input bit v, input logic [DW-1:0] d, input bit g);
        bit push;
        bit pop;
        bus.in_valid = v;
        bus.in_data  = d;
        bus.gnt      = g;
        push = v && (mcount != DP);
        pop  = g && (mcount != 0);
        @(posedge clk);
        if (g && mcount == 0) err_m = 1'b1;
        if (push) exp_q.push_back(d);
        mcount = mcount + int'(push) - int'(pop);
        #1;
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a word.
    initial begin
        forever begin
            @(negedge clk);
            chk("req", bus.req, mcount != 0);
            chk("in_ready", bus.in_ready, mcount != DP);
            chk("count", bus.count, mcount);
            chk("out_valid", bus.out_valid, bus.gnt && (mcount != 0));
`ifdef ARB_REQ_PORT_ERR_EN
            chk("gnt_err", gnt_err, err_m);
`endif
            if (mcount != 0 && exp_q.size() != 0) begin
                chk("head", bus.out_data, exp_q[0]);
            end
            if (bus.out_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("pop_nonempty", 1, 0);
                end else begin
                    chk("out_data", bus.out_data, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int idx;
        int cyc;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.gnt      = 1'b0;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        chk("rst_req", bus.req, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_count", bus.count, 0);
        chk("rst_out_data", bus.out_data, 0);

        // Spurious grant while empty.
        step(0, 8'h00, 1);
        step(0, 8'h00, 0);

        // Single word.
        step(1, 8'hA5, 0);
        chk("single_out_data", bus.out_data, 8'hA5);
        step(0, 8'h00, 0);
        step(0, 8'h00, 1);
        step(0, 8'h00, 0);

        // Fill to full, fifth word held off, then drain.
        for (int i = 1; i <= 4; i++) step(1, DW'(i), 0);
        chk("full_in_ready", bus.in_ready, 0);
        step(1, 8'h05, 0);
        for (int i = 0; i < 4; i++) step(0, 8'h00, 1);
        step(0, 8'h00, 0);

        // Simultaneous push/pop at full.
        for (int i = 1; i <= 4; i++) step(1, DW'(i), 0);
        step(1, 8'h05, 1);
        chk("full_pop_count", bus.count, 3);
        step(1, 8'h05, 1);
        chk("pushpop_count", bus.count, 3);
        for (int i = 0; i < 3; i++) step(0, 8'h00, 1);
        step(0, 8'h00, 0);

        // Pointer wrap: ten words with alternating grant.
        idx = 0;
        cyc = 0;
        while ((idx < 10 || mcount != 0) && cyc < 100) begin
            bit acc;
            acc = (idx < 10) && (mcount != DP);
            step(idx < 10, DW'(8'h10 + idx), cyc[0]);
            if (acc) idx++;
            cyc++;
        end
        chk("wrap_done", (idx == 10 && mcount == 0), 1);

        // Reset mid-operation.
        for (int i = 0; i < 3; i++) step(1, DW'(8'h30 + i), 0);
        #2 reset = 1'b0;
        mcount = 0;
        exp_q.delete();
        err_m = 1'b0;
        #1;
        chk("midrst_req", bus.req, 0);
        chk("midrst_count", bus.count, 0);
        @(posedge clk);
        #1 reset = 1'b1;
        chk("post_rst_in_ready", bus.in_ready, 1);
        step(0, 8'h00, 1);
        step(0, 8'h00, 0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 1), DW'($urandom), $urandom_range(0, 1));
        end
        cyc = 0;
        while (mcount != 0 && cyc < 20) begin
            step(0, 8'h00, 1);
            cyc++;
        end
        step(0, 8'h00, 0);
        chk("drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
